// File: rtl/simple_ecc_cache_pkg.sv
// rtl/simple_ecc_cache_pkg.sv - shared widths, FSM states and SECDED bit placement for the ECC data cache
package simple_ecc_cache_pkg;

  localparam int INDEX_W  = 9;
  localparam int MEM_AW   = 13;
  localparam int TAG_W    = MEM_AW - INDEX_W;
  localparam int DATA_W   = 32;
  localparam int CHK_W    = 7;
  localparam int SYN_W    = 6;
  localparam int LAST_POS = 38;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  // Hamming codeword position of each data bit: the non-power-of-two slots 3..38, LSB first.
  localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

endpackage

// File: rtl/simple_ecc_cache_secded_encoder.sv
// rtl/simple_ecc_cache_secded_encoder.sv - combinational (39,32) SECDED check-bit generator
module secded_encoder
  import simple_ecc_cache_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CHK_W-1:0]  chk_o
);

  logic [SYN_W-1:0] pos_par;

  // XOR of the positions of all set data bits gives the six Hamming check bits directly.
  always_comb begin
    pos_par = '0;
    for (int k = 0; k < DATA_W; k++) begin
      if (data_i[k]) begin
        pos_par = pos_par ^ DATA_POS[k];
      end
    end
  end

  // Overall parity bit covers data and the six Hamming bits.
  assign chk_o = {^{data_i, pos_par}, pos_par};

endmodule

// File: rtl/simple_ecc_cache.sv
// rtl/simple_ecc_cache.sv - direct-mapped SECDED-protected data cache with write-through backing memory
module simple_ecc_cache
  import simple_ecc_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               CPU_read_en,
  input  logic               CPU_write_en,
  input  logic [31:0]        CPU_addr,
  input  logic [DATA_W-1:0]  CPU_write_din,
  output logic [DATA_W-1:0]  CPU_read_dout,
  output logic               isCacheStall,
  output logic [CHK_W-1:0]   parity_bits,
  input  logic               mem_b_we,
  input  logic [MEM_AW-1:0]  mem_b_addr,
  input  logic [DATA_W-1:0]  mem_b_din,
  output logic [DATA_W-1:0]  mem_b_dout,
  input  logic               error_dwe,
  input  logic               error_pwe,
  input  logic [DATA_W-1:0]  error_din,
  input  logic [CHK_W-1:0]   error_pin,
  input  logic [INDEX_W-1:0] error_addr
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << MEM_AW;

  logic [DATA_W-1:0] mem_q       [WORDS];
  logic [DATA_W-1:0] line_data_q [LINES];
  logic [CHK_W-1:0]  line_chk_q  [LINES];
  logic [TAG_W-1:0]  line_tag_q  [LINES];
  logic [LINES-1:0]  line_valid_q;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] miss_addr_q;
  logic [DATA_W-1:0] fetch_q;
  logic [DATA_W-1:0] mem_b_dout_q;

  logic [MEM_AW-1:0]  cpu_word;
  logic [INDEX_W-1:0] cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               unused_addr;

  assign cpu_word    = CPU_addr[MEM_AW+1:2];
  assign cpu_idx     = cpu_word[INDEX_W-1:0];
  assign cpu_tag     = cpu_word[MEM_AW-1:INDEX_W];
  assign unused_addr = ^{CPU_addr[31:MEM_AW+2], CPU_addr[1:0]};

  // Decode of the addressed line.
  logic [DATA_W-1:0] rd_data;
  logic [CHK_W-1:0]  rd_chk;
  logic [CHK_W-1:0]  rd_recalc;
  logic [SYN_W-1:0]  syndrome;
  logic              overall_err;
  logic              uncorrectable;
  logic              single_err;
  logic              tag_match;
  logic              hit;
  logic [DATA_W-1:0] corr_data;

  assign rd_data = line_data_q[cpu_idx];
  assign rd_chk  = line_chk_q[cpu_idx];

  secded_encoder u_enc_rd (
    .data_i (rd_data),
    .chk_o  (rd_recalc)
  );

  assign syndrome    = rd_chk[SYN_W-1:0] ^ rd_recalc[SYN_W-1:0];
  assign overall_err = ^{rd_data, rd_chk};
  // Odd error count pointing outside the codeword, or even count with a syndrome, cannot be fixed.
  assign uncorrectable = overall_err ? (syndrome > 6'(LAST_POS)) : (syndrome != '0);
  assign single_err    = overall_err && !uncorrectable;
  assign tag_match     = line_valid_q[cpu_idx] && (line_tag_q[cpu_idx] == cpu_tag);
  assign hit           = tag_match && !uncorrectable;

  // Flip the data bit whose codeword position equals the syndrome; check-bit errors leave data alone.
  always_comb begin
    corr_data = rd_data;
    for (int k = 0; k < DATA_W; k++) begin
      if (DATA_POS[k] == syndrome) begin
        corr_data[k] = ~rd_data[k];
      end
    end
  end

  // Request qualification; stores and miss handling only start from IDLE.
  logic rd_req, idle, wr_fire, scrub, miss_start, stall;

  assign rd_req     = CPU_read_en && !CPU_write_en;
  assign idle       = (state_q == ST_IDLE);
  assign wr_fire    = CPU_write_en && idle;
  assign scrub      = idle && rd_req && hit && single_err;
  assign miss_start = idle && rd_req && !hit;

  // Miss sequencer next state and stall: stall covers the miss-detect cycle and FETCH.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (miss_start) begin
          state_d = ST_FETCH;
          stall   = 1'b1;
        end
      end
      ST_FETCH: begin
        state_d = ST_FILL;
        stall   = 1'b1;
      end
      ST_FILL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign isCacheStall  = stall & rst;
  assign CPU_read_dout = (state_q == ST_FILL) ? fetch_q : corr_data;
  assign mem_b_dout    = mem_b_dout_q;

  // Line write source: fill beats store, store beats scrub (they cannot coincide in practice).
  logic               line_we;
  logic [INDEX_W-1:0] line_widx;
  logic [TAG_W-1:0]   line_wtag;
  logic [DATA_W-1:0]  line_wdata;
  logic [CHK_W-1:0]   line_wchk;

  always_comb begin
    line_we    = 1'b0;
    line_widx  = cpu_idx;
    line_wtag  = cpu_tag;
    line_wdata = CPU_write_din;
    if (state_q == ST_FILL) begin
      line_we    = 1'b1;
      line_widx  = miss_addr_q[INDEX_W-1:0];
      line_wtag  = miss_addr_q[MEM_AW-1:INDEX_W];
      line_wdata = fetch_q;
    end else if (wr_fire) begin
      line_we    = 1'b1;
    end else if (scrub) begin
      line_we    = 1'b1;
      line_wdata = corr_data;
    end
  end

  secded_encoder u_enc_wr (
    .data_i (line_wdata),
    .chk_o  (line_wchk)
  );

  secded_encoder u_enc_par (
    .data_i (CPU_write_din),
    .chk_o  (parity_bits)
  );

  // Port-B write kills the line only if it holds that exact word after this edge's update.
  logic [INDEX_W-1:0] b_idx;
  logic [TAG_W-1:0]   b_tag;
  logic               b_kill;

  assign b_idx  = mem_b_addr[INDEX_W-1:0];
  assign b_tag  = mem_b_addr[MEM_AW-1:INDEX_W];
  assign b_kill = mem_b_we &&
                  ((line_we && (line_widx == b_idx)) ? (line_wtag == b_tag)
                                                     : (line_valid_q[b_idx] && (line_tag_q[b_idx] == b_tag)));

  // FSM state register; reset aborts any miss in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Valid bits and the port-B read register; invalidate is applied last so it wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid_q <= '0;
      mem_b_dout_q <= '0;
    end else begin
      mem_b_dout_q <= mem_q[mem_b_addr];
      if (line_we) begin
        line_valid_q[line_widx] <= 1'b1;
      end
      if (b_kill) begin
        line_valid_q[b_idx] <= 1'b0;
      end
    end
  end

  // Miss address capture and backing-memory fetch.
  always_ff @(posedge clk) begin
    if (miss_start) begin
      miss_addr_q <= cpu_word;
    end
    if (state_q == ST_FETCH) begin
      fetch_q <= mem_q[miss_addr_q];
    end
  end

  // Line arrays: CPU-side writes first, fault injection only when not colliding with them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_data_q[line_widx] <= line_wdata;
      line_chk_q[line_widx]  <= line_wchk;
      line_tag_q[line_widx]  <= line_wtag;
    end
    if (error_dwe && !(line_we && (line_widx == error_addr))) begin
      line_data_q[error_addr] <= error_din;
    end
    if (error_pwe && !(line_we && (line_widx == error_addr))) begin
      line_chk_q[error_addr] <= error_pin;
    end
  end

  // Backing memory: write-through from port A, port B overrides a same-word store.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[cpu_word] <= CPU_write_din;
    end
    if (mem_b_we) begin
      mem_q[mem_b_addr] <= mem_b_din;
    end
  end

endmodule

// File: tb/tb_simple_ecc_cache.sv
// tb/tb_simple_ecc_cache.sv - directed self-checking bench for simple_ecc_cache
module tb_simple_ecc_cache;

  logic        clk;
  logic        rst;
  logic        CPU_read_en;
  logic        CPU_write_en;
  logic [31:0] CPU_addr;
  logic [31:0] CPU_write_din;
  logic [31:0] CPU_read_dout;
  logic        isCacheStall;
  logic [6:0]  parity_bits;
  logic        mem_b_we;
  logic [12:0] mem_b_addr;
  logic [31:0] mem_b_din;
  logic [31:0] mem_b_dout;
  logic        error_dwe;
  logic        error_pwe;
  logic [31:0] error_din;
  logic [6:0]  error_pin;
  logic [8:0]  error_addr;

  int vecs = 0;
  int errs = 0;

  simple_ecc_cache dut (
    .clk           (clk),
    .rst           (rst),
    .CPU_read_en   (CPU_read_en),
    .CPU_write_en  (CPU_write_en),
    .CPU_addr      (CPU_addr),
    .CPU_write_din (CPU_write_din),
    .CPU_read_dout (CPU_read_dout),
    .isCacheStall  (isCacheStall),
    .parity_bits   (parity_bits),
    .mem_b_we      (mem_b_we),
    .mem_b_addr    (mem_b_addr),
    .mem_b_din     (mem_b_din),
    .mem_b_dout    (mem_b_dout),
    .error_dwe     (error_dwe),
    .error_pwe     (error_pwe),
    .error_din     (error_din),
    .error_pin     (error_pin),
    .error_addr    (error_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder built from an explicit 38-slot codeword.
  function automatic logic [6:0] ref_enc(input logic [31:0] d);
    logic [38:1] cw;
    logic [6:0]  c;
    int          k;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    c = '0;
    for (int i = 0; i < 6; i++) begin
      for (int p = 1; p <= 38; p++) begin
        if (p[i]) c[i] = c[i] ^ cw[p];
      end
    end
    c[6] = ^{d, c[5:0]};
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a);
    CPU_write_en = 1'b0;
    CPU_read_en  = 1'b1;
    CPU_addr     = a;
    #1;
  endtask

  // Full read miss: two stall cycles, then fetched data in the fill cycle.
  task automatic miss_seq(input string name, input logic [31:0] a, input logic [31:0] exp);
    load(a);
    chk({name, "_stall0"}, {31'b0, isCacheStall}, 32'd1);
    cyc();
    chk({name, "_stall1"}, {31'b0, isCacheStall}, 32'd1);
    cyc();
    chk({name, "_fill_stall"}, {31'b0, isCacheStall}, 32'd0);
    chk({name, "_fill_dout"}, CPU_read_dout, exp);
    cyc();
    CPU_read_en = 1'b0;
  endtask

  task automatic hit_seq(input string name, input logic [31:0] a, input logic [31:0] exp);
    load(a);
    chk({name, "_stall"}, {31'b0, isCacheStall}, 32'd0);
    chk({name, "_dout"}, CPU_read_dout, exp);
    cyc();
    CPU_read_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    CPU_read_en = 1'b0; CPU_write_en = 1'b0; CPU_addr = '0; CPU_write_din = '0;
    mem_b_we = 1'b0; mem_b_addr = '0; mem_b_din = '0;
    error_dwe = 1'b0; error_pwe = 1'b0; error_din = '0; error_pin = '0; error_addr = '0;
    #2;
    chk("rst_stall", {31'b0, isCacheStall}, 32'd0);
    chk("rst_bdout", mem_b_dout, 32'd0);
    cyc();
    rst = 1'b1;

    // Check-bit generator
    CPU_write_din = 32'h0;         #1; chk("par_zero", {25'b0, parity_bits}, 32'h00);
    CPU_write_din = 32'h1;         #1; chk("par_bit0", {25'b0, parity_bits}, 32'h43);
    CPU_write_din = 32'h2;         #1; chk("par_bit1", {25'b0, parity_bits}, 32'h45);
    CPU_write_din = 32'h10;        #1; chk("par_bit4", {25'b0, parity_bits}, 32'h49);
    CPU_write_din = 32'h3;         #1; chk("par_bits01", {25'b0, parity_bits}, 32'h06);
    CPU_write_din = 32'h12345678;  #1; chk("par_word", {25'b0, parity_bits}, {25'b0, ref_enc(32'h12345678)});

    // Store then load hit
    CPU_write_en = 1'b1; CPU_addr = 32'h40; CPU_write_din = 32'h12345678; #1;
    chk("store_stall", {31'b0, isCacheStall}, 32'd0);
    cyc();
    CPU_write_en = 1'b0;
    hit_seq("store_hit", 32'h40, 32'h12345678);

    // Port-B load then CPU miss
    mem_b_we = 1'b1; mem_b_addr = 13'h200; mem_b_din = 32'hCAFEF00D;
    cyc();
    mem_b_we = 1'b0;
    miss_seq("b_miss", 32'h800, 32'hCAFEF00D);
    hit_seq("b_rehit", 32'h800, 32'hCAFEF00D);
    cyc();
    chk("b_read", mem_b_dout, 32'hCAFEF00D);

    // Single-bit data error corrected and scrubbed
    error_dwe = 1'b1; error_addr = 9'h010; error_din = 32'h12345658;
    cyc();
    error_dwe = 1'b0;
    hit_seq("sbe_fix", 32'h40, 32'h12345678);
    // A check-bit flip on a scrubbed line is still a single error; on an unscrubbed one it is double.
    error_pwe = 1'b1; error_pin = ref_enc(32'h12345678) ^ 7'h01;
    cyc();
    error_pwe = 1'b0;
    hit_seq("scrubbed", 32'h40, 32'h12345678);

    // Double-bit error refetches from backing memory
    error_dwe = 1'b1; error_din = 32'h1234567B;
    cyc();
    error_dwe = 1'b0;
    miss_seq("dbe", 32'h40, 32'h12345678);
    hit_seq("dbe_rehit", 32'h40, 32'h12345678);

    // Read and write together: write wins, no stall
    CPU_read_en = 1'b1; CPU_write_en = 1'b1; CPU_addr = 32'h100; CPU_write_din = 32'hDEADBEEF; #1;
    chk("rw_stall", {31'b0, isCacheStall}, 32'd0);
    cyc();
    CPU_write_en = 1'b0;
    hit_seq("rw_hit", 32'h100, 32'hDEADBEEF);

    // Store, then port-B overwrite of the same word invalidates the line
    CPU_write_en = 1'b1; CPU_addr = 32'h48C; CPU_write_din = 32'h11111111;
    cyc();
    CPU_write_en = 1'b0;
    hit_seq("pre_b_hit", 32'h48C, 32'h11111111);
    mem_b_we = 1'b1; mem_b_addr = 13'h123; mem_b_din = 32'hAAAA5555;
    cyc();
    mem_b_we = 1'b0;
    miss_seq("b_inval", 32'h48C, 32'hAAAA5555);

    // Same-edge store and port-B write to one word
    CPU_write_en = 1'b1; CPU_addr = 32'h5158; CPU_write_din = 32'h11111111;
    mem_b_we = 1'b1; mem_b_addr = 13'h1456; mem_b_din = 32'hAAAA5555;
    cyc();
    CPU_write_en = 1'b0; mem_b_we = 1'b0;
    miss_seq("same_edge", 32'h5158, 32'hAAAA5555);
    cyc();
    chk("same_edge_mem", mem_b_dout, 32'hAAAA5555);

    // Reset in the middle of a miss
    load(32'h6000);
    chk("abort_stall0", {31'b0, isCacheStall}, 32'd1);
    cyc();
    chk("abort_fetch", {31'b0, isCacheStall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_drop", {31'b0, isCacheStall}, 32'd0);
    chk("abort_bdout", mem_b_dout, 32'd0);
    CPU_read_en = 1'b0;
    cyc();
    rst = 1'b1;
    miss_seq("post_rst", 32'h40, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
